// File: rtl/fl_checkpoint_ctrl.sv
// fl_checkpoint_ctrl: branch checkpoint controller for the physical-register
// free list. Gates allocation/freeing, records the free list read pointer per
// in-flight branch, and on a mispredict drives a one-cycle restore while
// squashing the mispredicted checkpoint and all younger ones.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   alloc_en, branch_valid         rename requests (register / checkpoint)
//   free_en, free_tag              retire frees one register
//   resolve_valid/_tag/_mispredict branch resolution
//   fl_r_ptr, fl_w_ptr, fl_list    free list state
//   fl_empty                       free list empty flag
//   fl_read_en, fl_write_en        free list pop / push strobes
//   fl_data_in                     register pushed back to the free list
//   fl_mispredict                  free list restore strobe (registered)
//   fl_re_r_ptr, fl_re_w_ptr       restore pointers
//   fl_re_list                     restore list image
//   ckpt_tag, ckpt_ready           tag for the next branch, slot available
//   ckpt_count                     number of valid checkpoints
//   rename_stall, recover_busy     rename hold, restore in progress
module fl_checkpoint_ctrl #(
  parameter int unsigned DEPTH    = 96,
  parameter int unsigned NUM_CKPT = 4,
  parameter int unsigned TAG_W    = $clog2(NUM_CKPT)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               alloc_en,
  input  logic                               branch_valid,
  input  logic                               free_en,
  input  logic [6:0]                         free_tag,
  input  logic                               resolve_valid,
  input  logic [TAG_W-1:0]                   resolve_tag,
  input  logic                               resolve_mispredict,
  input  logic [6:0]                         fl_r_ptr,
  input  logic [6:0]                         fl_w_ptr,
  input  logic [DEPTH-1:0][6:0]              fl_list,
  input  logic                               fl_empty,
  output logic                               fl_read_en,
  output logic                               fl_write_en,
  output logic [6:0]                         fl_data_in,
  output logic                               fl_mispredict,
  output logic [6:0]                         fl_re_r_ptr,
  output logic [6:0]                         fl_re_w_ptr,
  output logic [DEPTH-1:0][6:0]              fl_re_list,
  output logic [TAG_W-1:0]                   ckpt_tag,
  output logic                               ckpt_ready,
  output logic [$clog2(NUM_CKPT+1)-1:0]      ckpt_count,
  output logic                               rename_stall,
  output logic                               recover_busy
);

  localparam int unsigned PTR_W = 7;
  localparam int unsigned CNT_W = $clog2(NUM_CKPT+1);

  typedef enum logic {ST_IDLE = 1'b0, ST_RESTORE = 1'b1} state_e;

  state_e                               state_q, state_d;
  logic [NUM_CKPT-1:0]                  valid_q, valid_d;
  logic [NUM_CKPT-1:0][PTR_W-1:0]       ptr_q, ptr_d;
  logic [NUM_CKPT-1:0][NUM_CKPT-1:0]    mask_q, mask_d;
  logic [PTR_W-1:0]                     re_r_ptr_q, re_r_ptr_d;
  logic                                 res_hit;
  logic [PTR_W-1:0]                     saved_ptr;

  // Pointer advance with wrap at DEPTH-1.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p,
                                               input logic inc);
    if (!inc) return p;
    if (32'(p) == DEPTH - 1) return '0;
    return p + PTR_W'(1);
  endfunction

  // Lowest free checkpoint and population count of valid slots.
  always_comb begin
    ckpt_tag   = '0;
    ckpt_count = '0;
    for (int i = int'(NUM_CKPT) - 1; i >= 0; i--) begin
      if (!valid_q[i]) ckpt_tag = TAG_W'(i);
      ckpt_count = ckpt_count + CNT_W'(valid_q[i]);
    end
  end

  assign recover_busy  = (state_q == ST_RESTORE);
  assign fl_mispredict = (state_q == ST_RESTORE);
  assign fl_re_r_ptr   = re_r_ptr_q;
  assign ckpt_ready    = ~(&valid_q) & ~recover_busy;
  assign rename_stall  = (alloc_en & fl_empty) | (branch_valid & ~ckpt_ready) | recover_busy;
  assign fl_read_en    = alloc_en & ~rename_stall;
  // A free arriving during restore is folded into the restore image instead.
  assign fl_write_en   = free_en & ~recover_busy;
  assign fl_data_in    = free_tag;
  assign saved_ptr     = ptr_inc(fl_r_ptr, fl_read_en);
  assign res_hit       = resolve_valid && (32'(resolve_tag) < NUM_CKPT) && valid_q[resolve_tag];

  // Restore image: current free list plus any free landing in the restore cycle.
  always_comb begin
    fl_re_w_ptr = fl_w_ptr;
    fl_re_list  = fl_list;
    if (recover_busy) begin
      fl_re_w_ptr = ptr_inc(fl_w_ptr, free_en);
      if (free_en && (32'(fl_w_ptr) < DEPTH)) fl_re_list[fl_w_ptr] = free_tag;
    end
  end

  // Next-state: checkpoint bookkeeping and IDLE/RESTORE sequencing.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    ptr_d      = ptr_q;
    mask_d     = mask_q;
    re_r_ptr_d = re_r_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (res_hit && !resolve_mispredict) begin
          valid_d[resolve_tag] = 1'b0;
          for (int j = 0; j < int'(NUM_CKPT); j++) mask_d[j][resolve_tag] = 1'b0;
        end
        if (res_hit && resolve_mispredict) begin
          // Squash the branch and every checkpoint allocated after it.
          for (int j = 0; j < int'(NUM_CKPT); j++) begin
            if ((TAG_W'(j) == resolve_tag) || mask_q[j][resolve_tag]) valid_d[j] = 1'b0;
          end
          re_r_ptr_d = ptr_q[resolve_tag];
          state_d    = ST_RESTORE;
        end else if (branch_valid && !rename_stall) begin
          // valid_d already excludes a same-cycle correct resolve.
          mask_d[ckpt_tag]  = valid_d;
          ptr_d[ckpt_tag]   = saved_ptr;
          valid_d[ckpt_tag] = 1'b1;
        end
      end
      ST_RESTORE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      valid_q    <= '0;
      ptr_q      <= '0;
      mask_q     <= '0;
      re_r_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      ptr_q      <= ptr_d;
      mask_q     <= mask_d;
      re_r_ptr_q <= re_r_ptr_d;
    end
  end

endmodule

// File: tb/tb_fl_checkpoint_ctrl.sv
// Directed scoreboard bench for fl_checkpoint_ctrl: stimulus pushes
// time-stamped flag expectations and restore expectations; monitors compare.
module tb_fl_checkpoint_ctrl;

  localparam int DEPTH = 96;

  logic             clk = 1'b0;
  logic             reset;
  logic             alloc_en, branch_valid, free_en;
  logic [6:0]       free_tag;
  logic             resolve_valid, resolve_mispredict;
  logic [1:0]       resolve_tag;
  logic [6:0]       fl_r_ptr, fl_w_ptr;
  logic [DEPTH-1:0][6:0] fl_list;
  logic             fl_empty;
  logic             fl_read_en, fl_write_en, fl_mispredict;
  logic [6:0]       fl_data_in, fl_re_r_ptr, fl_re_w_ptr;
  logic [DEPTH-1:0][6:0] fl_re_list;
  logic [1:0]       ckpt_tag;
  logic             ckpt_ready;
  logic [2:0]       ckpt_count;
  logic             rename_stall, recover_busy;

  fl_checkpoint_ctrl #(.DEPTH(DEPTH), .NUM_CKPT(4)) dut (
    .clk(clk), .reset(reset), .alloc_en(alloc_en), .branch_valid(branch_valid),
    .free_en(free_en), .free_tag(free_tag), .resolve_valid(resolve_valid),
    .resolve_tag(resolve_tag), .resolve_mispredict(resolve_mispredict),
    .fl_r_ptr(fl_r_ptr), .fl_w_ptr(fl_w_ptr), .fl_list(fl_list), .fl_empty(fl_empty),
    .fl_read_en(fl_read_en), .fl_write_en(fl_write_en), .fl_data_in(fl_data_in),
    .fl_mispredict(fl_mispredict), .fl_re_r_ptr(fl_re_r_ptr), .fl_re_w_ptr(fl_re_w_ptr),
    .fl_re_list(fl_re_list), .ckpt_tag(ckpt_tag), .ckpt_ready(ckpt_ready),
    .ckpt_count(ckpt_count), .rename_stall(rename_stall), .recover_busy(recover_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {F_READY, F_TAG, F_COUNT, F_MISP, F_BUSY, F_RD, F_WR,
                    F_STALL, F_RE_R, F_RE_W, F_DATA} field_e;

  typedef struct {
    int    cyc;
    int    fld;
    int    val;
    string name;
  } exp_t;

  typedef struct {
    int r_ptr;
    int w_ptr;
    int idx;
    int val;
  } rst_exp_t;

  exp_t     sb[$];
  rst_exp_t rq[$];
  int       checks = 0;
  int       errors = 0;

  function automatic int rd_field(input int f);
    case (f)
      F_READY: return int'(ckpt_ready);
      F_TAG:   return int'(ckpt_tag);
      F_COUNT: return int'(ckpt_count);
      F_MISP:  return int'(fl_mispredict);
      F_BUSY:  return int'(recover_busy);
      F_RD:    return int'(fl_read_en);
      F_WR:    return int'(fl_write_en);
      F_STALL: return int'(rename_stall);
      F_RE_R:  return int'(fl_re_r_ptr);
      F_RE_W:  return int'(fl_re_w_ptr);
      F_DATA:  return int'(fl_data_in);
      default: return -1;
    endcase
  endfunction

  task automatic expect_at(input int dly, input int fld, input int val, input string nm);
    exp_t e;
    e.cyc = cyc + dly; e.fld = fld; e.val = val; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic expect_restore(input int r, input int w, input int idx, input int val);
    rst_exp_t e;
    e.r_ptr = r; e.w_ptr = w; e.idx = idx; e.val = val;
    rq.push_back(e);
  endtask

  // Flag monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        checks++;
        if (sb[i].cyc < cyc || rd_field(sb[i].fld) != sb[i].val) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%0d want=%0d", sb[i].name, cyc,
                   rd_field(sb[i].fld), sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  // Restore monitor: every fl_mispredict pulse must match a queued restore.
  always @(negedge clk) begin
    if (fl_mispredict) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_restore cyc=%0d got=1 want=0", cyc);
      end else begin
        rst_exp_t e;
        e = rq.pop_front();
        if (int'(fl_re_r_ptr) != e.r_ptr) begin
          errors++; $display("FAIL re_r_ptr cyc=%0d got=%0d want=%0d", cyc, fl_re_r_ptr, e.r_ptr);
        end
        checks++;
        if (int'(fl_re_w_ptr) != e.w_ptr) begin
          errors++; $display("FAIL re_w_ptr cyc=%0d got=%0d want=%0d", cyc, fl_re_w_ptr, e.w_ptr);
        end
        checks++;
        if (int'(fl_re_list[e.idx]) != e.val) begin
          errors++; $display("FAIL re_list[%0d] cyc=%0d got=%0d want=%0d", e.idx, cyc,
                             fl_re_list[e.idx], e.val);
        end
        checks++;
        if (fl_write_en !== 1'b0) begin
          errors++; $display("FAIL write_en_in_restore cyc=%0d got=%0b want=0", cyc, fl_write_en);
        end
      end
    end
  end

  task automatic idle_inputs();
    reset = 1'b0; alloc_en = 1'b0; branch_valid = 1'b0; free_en = 1'b0;
    free_tag = '0; resolve_valid = 1'b0; resolve_mispredict = 1'b0;
    resolve_tag = '0; fl_empty = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic resolve(input int tag, input logic mis);
    resolve_valid = 1'b1; resolve_tag = 2'(tag); resolve_mispredict = mis;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    fl_r_ptr = '0; fl_w_ptr = '0;
    for (int i = 0; i < DEPTH; i++) fl_list[i] = 7'(i);

    // Second reset cycle: reset values, enables follow inputs.
    next_cycle(); reset = 1'b1; alloc_en = 1'b1; free_en = 1'b1; free_tag = 7'd3;
    expect_at(0, F_READY, 1, "rst_ready");  expect_at(0, F_TAG, 0, "rst_tag");
    expect_at(0, F_COUNT, 0, "rst_count");  expect_at(0, F_MISP, 0, "rst_misp");
    expect_at(0, F_BUSY, 0, "rst_busy");    expect_at(0, F_RD, 1, "rst_rd_en");
    expect_at(0, F_WR, 1, "rst_wr_en");     expect_at(0, F_RE_W, 0, "rst_re_w");
    expect_at(0, F_DATA, 3, "rst_data_in");

    // Branches tag0..3, saved 6 / 9 / 12 / 20.
    next_cycle(); fl_r_ptr = 7'd5; alloc_en = 1'b1; branch_valid = 1'b1;
    expect_at(0, F_RD, 1, "b0_rd_en"); expect_at(0, F_STALL, 0, "b0_stall");
    expect_at(1, F_TAG, 1, "b0_next_tag"); expect_at(1, F_COUNT, 1, "b0_count");
    next_cycle(); fl_r_ptr = 7'd8; alloc_en = 1'b1; branch_valid = 1'b1;
    expect_at(1, F_TAG, 2, "b1_next_tag"); expect_at(1, F_COUNT, 2, "b1_count");
    next_cycle(); fl_r_ptr = 7'd11; alloc_en = 1'b1; branch_valid = 1'b1;
    expect_at(1, F_TAG, 3, "b2_next_tag"); expect_at(1, F_COUNT, 3, "b2_count");
    next_cycle(); fl_r_ptr = 7'd20; branch_valid = 1'b1;
    expect_at(0, F_RD, 0, "b3_rd_en");
    expect_at(1, F_COUNT, 4, "full_count"); expect_at(1, F_READY, 0, "full_ready");
    expect_at(1, F_TAG, 0, "full_tag");

    // 5th branch stalls; correct resolve of tag 2 frees a slot next cycle.
    next_cycle(); alloc_en = 1'b1; branch_valid = 1'b1; resolve(2, 1'b0);
    expect_at(0, F_STALL, 1, "full_stall"); expect_at(0, F_RD, 0, "full_rd_en");
    expect_at(0, F_READY, 0, "full_ready_same");
    expect_at(1, F_READY, 1, "res2_ready"); expect_at(1, F_TAG, 2, "res2_tag");
    expect_at(1, F_COUNT, 3, "res2_count");

    // Mispredict tag 1 with a new branch and a free in the same cycle.
    next_cycle(); fl_r_ptr = 7'd30; alloc_en = 1'b1; branch_valid = 1'b1;
    free_en = 1'b1; free_tag = 7'd50; fl_w_ptr = 7'd10; resolve(1, 1'b1);
    expect_at(0, F_RD, 1, "mp1_rd_en"); expect_at(0, F_WR, 1, "mp1_wr_en");
    expect_at(0, F_STALL, 0, "mp1_stall"); expect_at(0, F_RE_W, 10, "mp1_re_w_idle");
    expect_at(1, F_MISP, 1, "mp1_misp"); expect_at(1, F_BUSY, 1, "mp1_busy");
    expect_at(1, F_COUNT, 1, "mp1_count"); expect_at(1, F_RE_R, 9, "mp1_re_r");
    expect_at(1, F_TAG, 1, "mp1_tag");

    // RESTORE: inputs held, free folded into restore image at the wrap point.
    next_cycle(); alloc_en = 1'b1; branch_valid = 1'b1; free_en = 1'b1;
    free_tag = 7'd100; fl_w_ptr = 7'd95; resolve(0, 1'b1);
    expect_restore(9, 0, 95, 100);
    expect_at(0, F_RD, 0, "rs_rd_en"); expect_at(0, F_STALL, 1, "rs_stall");
    expect_at(0, F_READY, 0, "rs_ready");
    expect_at(1, F_MISP, 0, "rs_done_misp"); expect_at(1, F_BUSY, 0, "rs_done_busy");
    expect_at(1, F_COUNT, 1, "rs_done_count"); expect_at(1, F_READY, 1, "rs_done_ready");

    // Branch at r_ptr 95 -> saved 0 (tag 1).
    next_cycle(); fl_r_ptr = 7'd95; fl_w_ptr = 7'd0; alloc_en = 1'b1; branch_valid = 1'b1;
    expect_at(0, F_RD, 1, "wrap_rd_en");
    expect_at(1, F_COUNT, 2, "wrap_count"); expect_at(1, F_TAG, 2, "wrap_tag");
    next_cycle(); resolve(1, 1'b1);
    expect_at(1, F_MISP, 1, "mp_wrap_misp"); expect_at(1, F_COUNT, 1, "mp_wrap_count");
    next_cycle(); fl_w_ptr = 7'd40;
    expect_restore(0, 40, 40, 40);
    expect_at(1, F_MISP, 0, "mp_wrap_done");

    // Mispredict tag 0 (saved 6) with a free at index 0.
    next_cycle(); resolve(0, 1'b1);
    expect_at(1, F_COUNT, 0, "mp0_count");
    next_cycle(); fl_w_ptr = 7'd0; free_en = 1'b1; free_tag = 7'd77;
    expect_restore(6, 1, 0, 77);

    // Two branches, mispredict the younger, then reset during RESTORE.
    next_cycle(); fl_r_ptr = 7'd40; alloc_en = 1'b1; branch_valid = 1'b1;
    expect_at(1, F_COUNT, 1, "c0_count"); expect_at(1, F_TAG, 1, "c0_tag");
    next_cycle(); fl_r_ptr = 7'd50; branch_valid = 1'b1;
    expect_at(1, F_COUNT, 2, "c1_count");
    next_cycle(); resolve(1, 1'b1);
    expect_at(1, F_MISP, 1, "c1_misp"); expect_at(1, F_COUNT, 1, "c1_mp_count");
    next_cycle(); reset = 1'b1;
    expect_restore(50, 0, 1, 1);
    expect_at(1, F_MISP, 0, "rrst_misp"); expect_at(1, F_BUSY, 0, "rrst_busy");
    expect_at(1, F_COUNT, 0, "rrst_count"); expect_at(1, F_RE_R, 0, "rrst_re_r");
    expect_at(1, F_TAG, 0, "rrst_tag"); expect_at(1, F_READY, 1, "rrst_ready");

    // Empty free list stalls rename and blocks the checkpoint.
    next_cycle(); alloc_en = 1'b1; branch_valid = 1'b1; fl_empty = 1'b1;
    expect_at(0, F_STALL, 1, "empty_stall"); expect_at(0, F_RD, 0, "empty_rd_en");
    expect_at(1, F_COUNT, 0, "empty_count");

    // Resolve on an invalid tag is ignored.
    next_cycle(); resolve(3, 1'b1);
    expect_at(1, F_MISP, 0, "inv_misp"); expect_at(1, F_COUNT, 0, "inv_count");

    next_cycle();
    next_cycle();
    @(negedge clk); #1;
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL pending_flag_checks got=%0d want=0", sb.size());
    end
    checks++;
    if (rq.size() != 0) begin
      errors++; $display("FAIL missing_restores got=%0d want=0", rq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fl_checkpoint_ctrl.md
# fl_checkpoint_ctrl

Branch checkpoint controller for the physical-register free list. It sits between rename/retire and the free list. It gates allocation (`read_en`) and freeing (`write_en`), and it records the free list read pointer for each in-flight branch. On a branch mispredict it drives the free list restore port (`mispredict`, `re_r_ptr`, `re_w_ptr`, `re_list`) for one cycle. It also squashes the checkpoint of the mispredicted branch and of every younger branch.

## Interface
Parameters:
- `DEPTH`, 96: free list entries; pointers wrap from DEPTH-1 to 0.
- `NUM_CKPT`, 4: in-flight branch checkpoints.
- `TAG_W`, `$clog2(NUM_CKPT)`: checkpoint tag width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `alloc_en`  in  1  rename needs one physical register this cycle.
- `branch_valid`  in  1  the renamed instruction is a branch and needs a checkpoint.
- `free_en`  in  1  retire frees one register.
- `free_tag`  in  7  the register being freed.
- `resolve_valid`  in  1  a branch resolved.
- `resolve_tag`  in  TAG_W  checkpoint tag of the resolved branch.
- `resolve_mispredict`  in  1  the resolved branch was mispredicted.
- `fl_r_ptr`, `fl_w_ptr`  in  7  free list `r_ptr_out` / `w_ptr_out`.
- `fl_list`  in  7 x DEPTH  free list `list_out`.
- `fl_empty`  in  1  free list `empty`.
- `fl_read_en`, `fl_write_en`  out  1  to free list `read_en` / `write_en`.
- `fl_data_in`  out  7  to free list `data_in`.
- `fl_mispredict`  out  1  to free list `mispredict`.
- `fl_re_r_ptr`, `fl_re_w_ptr`  out  7  restore pointers.
- `fl_re_list`  out  7 x DEPTH  restore list.
- `ckpt_tag`  out  TAG_W  tag the current branch receives.
- `ckpt_ready`  out  1  at least one checkpoint is free.
- `ckpt_count`  out  `$clog2(NUM_CKPT+1)`  number of valid checkpoints.
- `rename_stall`  out  1  rename must hold its inputs.
- `recover_busy`  out  1  a restore is in progress.

## Operation
- Per-checkpoint state:
  - `valid`.
  - `saved_ptr[6:0]`.
  - `older_mask[NUM_CKPT-1:0]`: the set of checkpoints that were valid when this one was allocated.
- Flag definitions:
  - `ckpt_ready` = not all valid, and not `recover_busy`.
  - `ckpt_tag` = lowest-index invalid checkpoint, or 0 when all are valid.
  - `rename_stall` = `(alloc_en & fl_empty) | (branch_valid & ~ckpt_ready) | recover_busy`.
- Allocation:
  - `fl_read_en` = `alloc_en & ~rename_stall`.
  - A checkpoint is allocated when `branch_valid & ~rename_stall`.
  - `saved_ptr` = `(fl_r_ptr + fl_read_en) mod DEPTH`, i.e. the pointer after the branch's own destination allocation.
  - `older_mask` = the current valid vector.
- Correct resolve (`resolve_valid & ~resolve_mispredict` on a valid tag):
  - Clear that tag's valid bit.
  - Clear that tag's bit in every `older_mask`.
- Mispredict resolve (valid tag t):
  - Clear t and every checkpoint j with `older_mask[j][t]`=1.
  - Latch `saved_ptr[t]` into `fl_re_r_ptr`.
  - FSM IDLE -> RESTORE.
- A resolve on an invalid tag is ignored.
- FSM:
  - IDLE: normal operation.
  - RESTORE: lasts exactly one cycle, then returns to IDLE. During RESTORE:
    - `fl_mispredict`=1 and `recover_busy`=1.
    - `branch_valid`, `alloc_en` and `resolve_valid` are ignored; upstream holds them.
- Freeing in IDLE: `fl_write_en`=`free_en`, `fl_data_in`=`free_tag`.
- Freeing in RESTORE:
  - `fl_write_en`=0, so the free is not lost under the restore.
  - `fl_re_w_ptr` = `(fl_w_ptr + free_en) mod DEPTH`.
  - `fl_re_list` = `fl_list`, with entry `fl_w_ptr` replaced by `free_tag` when `free_en`=1.
- Outside RESTORE: `fl_re_w_ptr`=`fl_w_ptr`, `fl_re_list`=`fl_list`.
- Simultaneous events in one cycle:
  - Correct resolve plus new branch: the freed slot is not reusable until the next cycle, because `ckpt_ready` comes from registered valid bits.
  - Mispredict plus new branch: the mispredict wins. No checkpoint is allocated, but `fl_read_en` still follows the IDLE rule.
  - Mispredict plus free: the free is applied normally in IDLE.
- Reset values:
  - All `valid`=0; FSM=IDLE.
  - `fl_re_r_ptr`=0, `fl_mispredict`=0, `recover_busy`=0.
  - `ckpt_ready`=1, `ckpt_tag`=0, `ckpt_count`=0.
  - `fl_read_en`/`fl_write_en` follow their inputs.
- Reset asserted during RESTORE forces IDLE; `fl_mispredict`=0 in the next cycle.

## Timing
- Checkpoint allocation: `valid`, `saved_ptr` and `ckpt_count` update at the edge ending the branch cycle. The new `ckpt_tag` is visible in the next cycle.
- Mispredict sampled in cycle N:
  - Checkpoints are cleared at the end of N.
  - RESTORE occupies cycle N+1 with `fl_mispredict`=1.
  - The free list loads the restore values at the end of N+1.
  - Rename resumes in N+2.
- Correct resolve in cycle N: the slot is free in cycle N+1.
- `fl_read_en`, `fl_write_en`, `rename_stall`, `ckpt_tag` and `ckpt_ready` are combinational from inputs and registered state.

## Test plan
- Reset for 2 cycles -> `ckpt_ready`=1, `ckpt_tag`=0, `ckpt_count`=0, `fl_mispredict`=0, `recover_busy`=0.
- `fl_r_ptr`=5 with `alloc_en`=1 and `branch_valid`=1 -> `fl_read_en`=1; next cycle `saved_ptr[0]`=6, `ckpt_tag`=1, `ckpt_count`=1.
- Fill 4 checkpoints, then a 5th branch -> `rename_stall`=1, `fl_read_en`=0. Correct resolve of tag 2 -> next cycle `ckpt_ready`=1, `ckpt_tag`=2, `ckpt_count`=3.
- Checkpoints 0/1/2 hold saved pointers 6/9/12 (in age order); mispredict tag 1 -> next cycle `fl_mispredict`=1, `fl_re_r_ptr`=9, `recover_busy`=1, `ckpt_count`=1 (only tag 0 valid). The cycle after -> `fl_mispredict`=0.
- In RESTORE with `free_en`=1, `free_tag`=100, `fl_w_ptr`=95 -> `fl_write_en`=0, `fl_re_w_ptr`=0, `fl_re_list[95]`=100.
- `fl_r_ptr`=95 with `alloc_en`=1 and a branch -> saved pointer is 0 (wrap). Reset asserted during RESTORE -> next cycle `fl_mispredict`=0, `ckpt_count`=0.
